// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - SECDED code helpers, decode result and scrub state types
package ecc_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CHK_W  = 8;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, FIX} scrub_state_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  sbe;
    logic                  dbe;
  } dec_result_t;

  // Hamming check bits plus one overall parity bit
  function automatic int calc_chk_w(input int data_w);
    int c;
    c = 1;
    for (int k = 0; k < 16; k++)
      if ((1 << c) < data_w + c + 1) c++;
    return c + 1;
  endfunction

  // Data bits occupy the non-power-of-two Hamming positions 3,5,6,7,9...;
  // chk[ham_w-1:0] are the Hamming bits, chk[ham_w] the overall parity.
  function automatic logic [MAX_CHK_W-1:0] ecc_encode(input logic [MAX_DATA_W-1:0] data,
                                                      input int data_w);
    logic [MAX_CHK_W-1:0] chk;
    logic                 par;
    int                   ham_w;
    int                   pos;
    ham_w = calc_chk_w(data_w) - 1;
    chk   = '0;
    par   = 1'b0;
    pos   = 2;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        pos++;
        if ((pos & (pos - 1)) == 0) pos++;
        for (int j = 0; j < MAX_CHK_W - 1; j++)
          if (j < ham_w && pos[j]) chk[j] = chk[j] ^ data[i];
        par = par ^ data[i];
      end
    end
    for (int j = 0; j < MAX_CHK_W - 1; j++)
      if (j < ham_w) par = par ^ chk[j];
    chk[ham_w] = par;
    return chk;
  endfunction

  function automatic dec_result_t ecc_decode(input logic [MAX_DATA_W-1:0] data,
                                             input logic [MAX_CHK_W-1:0]  chk,
                                             input int data_w);
    dec_result_t          res;
    logic [MAX_CHK_W-1:0] exp_chk;
    logic                 par;
    logic                 hit;
    int                   ham_w;
    int                   syn;
    int                   pos;
    ham_w   = calc_chk_w(data_w) - 1;
    exp_chk = ecc_encode(data, data_w);
    syn     = 0;
    par     = chk[ham_w];
    for (int j = 0; j < MAX_CHK_W - 1; j++) begin
      if (j < ham_w) begin
        if (exp_chk[j] != chk[j]) syn = syn | (1 << j);
        par = par ^ chk[j];
      end
    end
    for (int i = 0; i < MAX_DATA_W; i++)
      if (i < data_w) par = par ^ data[i];
    res.data = data;
    res.sbe  = 1'b0;
    res.dbe  = 1'b0;
    hit      = 1'b0;
    if (par) begin
      pos = 2;
      for (int i = 0; i < MAX_DATA_W; i++) begin
        if (i < data_w) begin
          pos++;
          if ((pos & (pos - 1)) == 0) pos++;
          if (pos == syn) begin
            res.data[i] = ~data[i];
            hit         = 1'b1;
          end
        end
      end
      // zero or power-of-two syndrome means the flip hit a check/parity bit
      if (hit || (syn & (syn - 1)) == 0) res.sbe = 1'b1;
      else                               res.dbe = 1'b1;
    end else if (syn != 0) begin
      res.dbe = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// rtl/secded_codec.sv - combinational SECDED decoder for one stored codeword
module secded_codec
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CHK_W  = calc_chk_w(DATA_W)
) (
  input  logic [DATA_W+CHK_W-1:0] code,
  output logic [DATA_W-1:0]       data,
  output logic                    sbe,
  output logic                    dbe
);

  dec_result_t res;

  always_comb begin
    res  = ecc_decode(MAX_DATA_W'(code[DATA_W-1:0]),
                      MAX_CHK_W'(code[DATA_W+CHK_W-1:DATA_W]), DATA_W);
    data = DATA_W'(res.data);
    sbe  = res.sbe;
    dbe  = res.dbe;
  end

endmodule

// File: rtl/ecc_reg_bank.sv
// rtl/ecc_reg_bank.sv - SECDED register bank with read port, injection and scrubber
module ecc_reg_bank
  import ecc_pkg::*;
#(
  parameter  int NUM_REGS       = 100,
  parameter  int DATA_W         = 8,
  parameter  int SCRUB_INTERVAL = 16,
  parameter  int CNT_W          = 8,
  localparam int CHK_W          = calc_chk_w(DATA_W),
  localparam int IDX_W          = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    w_en,
  input  logic [IDX_W-1:0]        w_idx,
  input  logic [DATA_W-1:0]       w_din,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_dout,
  output logic                    rd_valid,
  output logic                    rd_sbe,
  output logic                    rd_dbe,
  input  logic                    scrub_en,
  input  logic                    inj_en,
  input  logic [IDX_W-1:0]        inj_idx,
  input  logic [DATA_W+CHK_W-1:0] inj_mask,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        sbe_cnt,
  output logic [CNT_W-1:0]        dbe_cnt,
  output logic [NUM_REGS-1:0]     dbe_flag
);

  localparam int CW_W = DATA_W + CHK_W;
  localparam int IV_W = $clog2(SCRUB_INTERVAL + 1);

  logic [CW_W-1:0]     mem [NUM_REGS];
  scrub_state_e        state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_next;
  logic [IV_W-1:0]     iv_cnt;

  logic                w_ok, inj_ok, rd_ok;
  logic [CW_W-1:0]     rd_code, sc_code;
  logic [DATA_W-1:0]   rd_dec_data, sc_data;
  logic                rd_dec_sbe, rd_dec_dbe, sc_sbe, sc_dbe;
  logic                sc_check, fix_go;
  logic [NUM_REGS-1:0] flag_next;

  function automatic logic [CW_W-1:0] make_word(input logic [DATA_W-1:0] d);
    return {CHK_W'(ecc_encode(MAX_DATA_W'(d), DATA_W)), d};
  endfunction

  assign w_ok     = w_en && (int'(w_idx) < NUM_REGS);
  assign inj_ok   = inj_en && (int'(inj_idx) < NUM_REGS);
  assign rd_ok    = int'(rd_idx) < NUM_REGS;
  assign rd_code  = rd_ok ? mem[rd_idx] : '0;
  assign sc_code  = mem[ptr];
  assign ptr_next = (ptr == IDX_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign sc_check = scrub_en && (state == CHECK);
  assign fix_go   = scrub_en && (state == FIX) && !sc_dbe;

  secded_codec #(.DATA_W(DATA_W)) u_rd_codec (
    .code(rd_code), .data(rd_dec_data), .sbe(rd_dec_sbe), .dbe(rd_dec_dbe)
  );

  secded_codec #(.DATA_W(DATA_W)) u_sc_codec (
    .code(sc_code), .data(sc_data), .sbe(sc_sbe), .dbe(sc_dbe)
  );

  // Later assignments win at a shared index: write > inject > fix
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      if (fix_go) mem[ptr] <= make_word(sc_data);
      if (inj_ok) mem[inj_idx] <= mem[inj_idx] ^ inj_mask;
      if (w_ok)   mem[w_idx] <= make_word(w_din);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      ptr    <= '0;
      iv_cnt <= '0;
    end else if (!scrub_en) begin
      state  <= IDLE;
      iv_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          if (iv_cnt == IV_W'(SCRUB_INTERVAL - 1)) begin
            iv_cnt <= '0;
            state  <= CHECK;
          end else begin
            iv_cnt <= iv_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (sc_sbe) begin
            state <= FIX;
          end else begin
            ptr   <= ptr_next;
            state <= WAIT;
          end
        end
        FIX: begin
          ptr   <= ptr_next;
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else if (cnt_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (sc_check && sc_sbe && sbe_cnt != '1) sbe_cnt <= sbe_cnt + 1'b1;
      if (sc_check && sc_dbe && dbe_cnt != '1) dbe_cnt <= dbe_cnt + 1'b1;
    end
  end

  always_comb begin
    flag_next = dbe_flag;
    if (sc_check && sc_dbe)          flag_next[ptr]    = 1'b1;
    if (rd_en && rd_ok && rd_dec_dbe) flag_next[rd_idx] = 1'b1;
    if (w_ok)                         flag_next[w_idx]  = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)     dbe_flag <= '0;
    else if (cnt_clr) dbe_flag <= '0;
    else              dbe_flag <= flag_next;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_valid <= 1'b0;
      rd_dout  <= '0;
      rd_sbe   <= 1'b0;
      rd_dbe   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_sbe   <= rd_en & rd_dec_sbe;
      rd_dbe   <= rd_en & rd_dec_dbe;
      if (rd_en) rd_dout <= rd_dec_data;
    end
  end

endmodule
